// File: rtl/z16_sequencer.sv
// rtl/z16_sequencer.sv - Z16 multi-cycle fetch/decode/execute/mem/writeback sequencer
module z16_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_halt,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_rdata,
    output logic [15:0] o_instr,
    input  logic        i_rd_wen,
    input  logic        i_mem_wen,
    input  logic        i_jump,
    input  logic [15:0] i_jump_addr,
    output logic        o_dmem_req,
    input  logic        i_dmem_ack,
    output logic        o_rd_wen,
    output logic        o_retire,
    output logic [15:0] o_pc,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [15:0] PC_INIT = {RESET_PC[15:1], 1'b0};

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] jump_target;
    logic        jump_pending;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        retire_q;

    // Request/strobe flops are set on the transition into the state that owns them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            pc           <= PC_INIT;
            ir           <= 16'h0000;
            jump_target  <= 16'h0000;
            jump_pending <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            retire_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!i_halt) begin
                        state      <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        ir         <= i_imem_rdata;
                        state      <= S_DECODE;
                        imem_req_q <= 1'b0;
                    end
                end
                S_DECODE: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    jump_pending <= i_jump;
                    jump_target  <= {i_jump_addr[15:1], 1'b0};
                    if (i_mem_wen) begin
                        state      <= S_MEM;
                        dmem_req_q <= 1'b1;
                    end else begin
                        state    <= S_WB;
                        retire_q <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (i_dmem_ack) begin
                        state      <= S_WB;
                        dmem_req_q <= 1'b0;
                        retire_q   <= 1'b1;
                    end
                end
                S_WB: begin
                    retire_q <= 1'b0;
                    pc       <= jump_pending ? jump_target : pc + 16'd2;
                    if (i_halt) begin
                        state <= S_IDLE;
                    end else begin
                        state      <= S_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    retire_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req  = imem_req_q;
    assign o_imem_addr = pc;
    assign o_instr     = ir;
    assign o_dmem_req  = dmem_req_q;
    assign o_retire    = retire_q;
    // retire_q is high only in WB, so this is the decoder enable gated to WB.
    assign o_rd_wen    = retire_q & i_rd_wen;
    assign o_pc        = pc;
    assign o_state     = state;

endmodule
